// File: rtl/data_bus_arbiter.sv
// ---------------------------------------------------------------------------
// data_bus_arbiter
//
// Two-master, one-slave arbiter for the shared data-memory port.
//   master 0 : core LSU data bus
//   master 1 : secondary requester (program loader / DMA)
//   slave    : data RAM, accepts one request per cycle and returns read data
//              exactly RD_LAT cycles after accepting a read.
//
// Handshake: a master raises mN_req_i with its attributes and holds them
// until mN_gnt_o is seen high in the same cycle; that cycle is the transfer.
// Dropping req before the grant cancels the access. Writes complete at the
// grant. Reads return mN_rvalid_o/mN_rdata_o for exactly one cycle, RD_LAT
// cycles after the grant; no new grant is issued while a read is pending.
//
// Ports:
//   clk_i, arst_i                 clock (rising edge), async active-high reset
//   mN_req_i/we_i/be_i/addr_i/wdata_i   master N request and attributes
//   mN_gnt_o                      master N request accepted this cycle
//   mN_rvalid_o, mN_rdata_o       master N read data return
//   data_req_o/we_o/be_o/addr_o/wdata_o  slave request and attributes
//   data_rdata_i                  slave read data
//
// Parameter:
//   RD_LAT  read latency of the slave in cycles, legal range 1..7
// ---------------------------------------------------------------------------
module data_bus_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk_i,
    input  logic        arst_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,

    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_RWAIT = 1'b1;

    localparam logic [2:0] WCNT_INIT = 3'(RD_LAT - 1);

    logic [0:0] state;
    logic       owner;
    logic       last;
    logic [2:0] wcnt;

    logic       gnt0;
    logic       gnt1;
    logic       any_gnt;
    logic       sel_we;
    logic       rd_done;

    // Round-robin: under contention the master that was not granted last
    // wins. last resets to 1 so master 0 takes the first conflict.
    always_comb begin
        gnt0    = (state == ST_IDLE) & m0_req_i & (~m1_req_i | last);
        gnt1    = (state == ST_IDLE) & m1_req_i & (~m0_req_i | ~last);
        any_gnt = gnt0 | gnt1;
        sel_we  = gnt1 ? m1_we_i : m0_we_i;
        rd_done = (state == ST_RWAIT) && (wcnt == 3'd0);
    end

    // All outputs are held at zero while reset is asserted, independently
    // of what the masters are driving.
    always_comb begin
        m0_gnt_o     = ~arst_i & gnt0;
        m1_gnt_o     = ~arst_i & gnt1;
        data_req_o   = ~arst_i & any_gnt;
        data_we_o    = 1'b0;
        data_be_o    = 4'd0;
        data_addr_o  = 32'd0;
        data_wdata_o = 32'd0;
        if (!arst_i && gnt0) begin
            data_we_o    = m0_we_i;
            data_be_o    = m0_be_i;
            data_addr_o  = m0_addr_i;
            data_wdata_o = m0_wdata_i;
        end else if (!arst_i && gnt1) begin
            data_we_o    = m1_we_i;
            data_be_o    = m1_be_i;
            data_addr_o  = m1_addr_i;
            data_wdata_o = m1_wdata_i;
        end
        m0_rvalid_o = ~arst_i & rd_done & ~owner;
        m1_rvalid_o = ~arst_i & rd_done & owner;
        m0_rdata_o  = m0_rvalid_o ? data_rdata_i : 32'd0;
        m1_rdata_o  = m1_rvalid_o ? data_rdata_i : 32'd0;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state <= ST_IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
            wcnt  <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_gnt) begin
                        last <= gnt1;
                        if (!sel_we) begin
                            owner <= gnt1;
                            wcnt  <= WCNT_INIT;
                            state <= ST_RWAIT;
                        end
                    end
                end
                ST_RWAIT: begin
                    // Data is delivered in the wcnt == 0 cycle; arbitration
                    // resumes on the following cycle.
                    if (wcnt == 3'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        wcnt <= wcnt - 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
